// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-port arbiter in front of an asynchronous 16-bit SRAM. Port A (CPU) and
// port B (loader/debug) each raise Req and hold it until their Done pulse.
// Every access takes three cycles: one IDLE cycle where the grant is decided,
// then ACC1 and ACC2 with the SRAM strobes active. The Done pulse (and RData on
// a read) appears in the IDLE cycle that follows ACC2. When both ports want the
// SRAM in the same IDLE cycle, the port that did not own the last access wins.
//
// Ports
//   Clk, Reset                     clock, synchronous active-high reset
//   A_Req/A_WE/A_Addr/A_WData      port A request, direction, address, data
//   A_Done/A_RData                 port A completion pulse and read data
//   B_*                            same set for port B
//   Mem_Addr/Mem_DOut/Mem_DrvEn    registered SRAM address, write data, bus drive
//   Mem_DIn                        SRAM read data
//   Mem_CE/Mem_UB/Mem_LB           active-low selects, permanently enabled
//   Mem_OE/Mem_WE                  active-low registered SRAM strobes
//   Owner                          last granted port (0 = A, 1 = B)
//   Busy                           access in progress (ACC1 or ACC2)
// -----------------------------------------------------------------------------
module mem_arbiter (
  input  logic        Clk,
  input  logic        Reset,

  input  logic        A_Req,
  input  logic        A_WE,
  input  logic [19:0] A_Addr,
  input  logic [15:0] A_WData,
  output logic        A_Done,
  output logic [15:0] A_RData,

  input  logic        B_Req,
  input  logic        B_WE,
  input  logic [19:0] B_Addr,
  input  logic [15:0] B_WData,
  output logic        B_Done,
  output logic [15:0] B_RData,

  output logic [19:0] Mem_Addr,
  output logic [15:0] Mem_DOut,
  output logic        Mem_DrvEn,
  input  logic [15:0] Mem_DIn,
  output logic        Mem_CE,
  output logic        Mem_UB,
  output logic        Mem_LB,
  output logic        Mem_OE,
  output logic        Mem_WE,

  output logic        Owner,
  output logic        Busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC1 = 2'd1;
  localparam logic [1:0] ACC2 = 2'd2;

  logic [1:0]  state_q,   state_d;
  logic        owner_q,   owner_d;
  logic        we_q,      we_d;
  logic [19:0] addr_q,    addr_d;
  logic [15:0] dout_q,    dout_d;
  logic        mem_oe_q,  mem_oe_d;
  logic        mem_we_q,  mem_we_d;
  logic        drv_q,     drv_d;
  logic        a_done_q,  a_done_d;
  logic        b_done_q,  b_done_d;
  logic [15:0] a_rdata_q, a_rdata_d;
  logic [15:0] b_rdata_q, b_rdata_d;

  logic a_elig;
  logic b_elig;
  logic grant_b;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case
    // leaves a signal unassigned; that is what keeps this block latch-free.
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    dout_d    = dout_q;
    mem_oe_d  = mem_oe_q;
    mem_we_d  = mem_we_q;
    drv_d     = drv_q;
    a_done_d  = 1'b0;
    b_done_d  = 1'b0;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;

    // A port whose Done is showing this cycle still has Req high from the
    // access just finished; masking it stops that stale Req from re-granting.
    a_elig  = A_Req & ~a_done_q;
    b_elig  = B_Req & ~b_done_q;
    // On a tie the port that did not own the last access goes next.
    grant_b = (a_elig & b_elig) ? ~owner_q : b_elig;

    case (state_q)
      IDLE: begin
        if (a_elig | b_elig) begin
          state_d  = ACC1;
          owner_d  = grant_b;
          we_d     = grant_b ? B_WE    : A_WE;
          addr_d   = grant_b ? B_Addr  : A_Addr;
          dout_d   = grant_b ? B_WData : A_WData;
          // Strobes are registered so they are clean from the first ACC1 edge;
          // exactly one of OE/WE goes low, never both.
          mem_oe_d = we_d;
          mem_we_d = ~we_d;
          drv_d    = we_d;
        end
      end
      ACC1: state_d = ACC2;
      ACC2: begin
        state_d  = IDLE;
        mem_oe_d = 1'b1;
        mem_we_d = 1'b1;
        drv_d    = 1'b0;
        a_done_d = ~owner_q;
        b_done_d = owner_q;
        // SRAM data has had both access cycles to settle; take it now.
        if (!we_q) begin
          if (owner_q) b_rdata_d = Mem_DIn;
          else         a_rdata_d = Mem_DIn;
        end
      end
      default: begin
        state_d  = IDLE;
        mem_oe_d = 1'b1;
        mem_we_d = 1'b1;
        drv_d    = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      dout_q    <= '0;
      mem_oe_q  <= 1'b1;
      mem_we_q  <= 1'b1;
      drv_q     <= 1'b0;
      a_done_q  <= 1'b0;
      b_done_q  <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      mem_oe_q  <= mem_oe_d;
      mem_we_q  <= mem_we_d;
      drv_q     <= drv_d;
      a_done_q  <= a_done_d;
      b_done_q  <= b_done_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign A_Done    = a_done_q;
  assign B_Done    = b_done_q;
  assign A_RData   = a_rdata_q;
  assign B_RData   = b_rdata_q;
  assign Mem_Addr  = addr_q;
  assign Mem_DOut  = dout_q;
  assign Mem_DrvEn = drv_q;
  assign Mem_OE    = mem_oe_q;
  assign Mem_WE    = mem_we_q;
  assign Mem_CE    = 1'b0;
  assign Mem_UB    = 1'b0;
  assign Mem_LB    = 1'b0;
  assign Owner     = owner_q;
  assign Busy      = (state_q == ACC1) | (state_q == ACC2);

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. A transaction-level model tracks the access
// in flight as "granted transaction + cycles still to run" and predicts every
// output; a compare process checks the DUT against it on each falling edge.
// Directed sequences add literal expectations at the interesting cycles.
// A small SRAM model answers the DUT's strobes on Mem_DIn.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_we, b_req, b_we;
  logic [19:0] a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_done, b_done;
  logic [15:0] a_rdata, b_rdata;
  logic [19:0] mem_addr;
  logic [15:0] mem_dout, mem_din;
  logic        mem_drv_en, mem_ce, mem_ub, mem_lb, mem_oe, mem_we;
  logic        owner, busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .Clk(clk), .Reset(rst),
    .A_Req(a_req), .A_WE(a_we), .A_Addr(a_addr), .A_WData(a_wdata),
    .A_Done(a_done), .A_RData(a_rdata),
    .B_Req(b_req), .B_WE(b_we), .B_Addr(b_addr), .B_WData(b_wdata),
    .B_Done(b_done), .B_RData(b_rdata),
    .Mem_Addr(mem_addr), .Mem_DOut(mem_dout), .Mem_DrvEn(mem_drv_en),
    .Mem_DIn(mem_din), .Mem_CE(mem_ce), .Mem_UB(mem_ub), .Mem_LB(mem_lb),
    .Mem_OE(mem_oe), .Mem_WE(mem_we), .Owner(owner), .Busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] init_val(input int i);
    case (i)
      1:       return 16'h1111;
      2:       return 16'h2222;
      8'h30:   return 16'hCAFE;
      default: return 16'(i * 16'h0101) ^ 16'h5A5A;
    endcase
  endfunction

  // ---------------- SRAM stand-in driven by the DUT pins ----------------
  logic [15:0] sram [0:255];
  bit          sram_ready = 1'b0;

  always @(posedge clk) begin
    if (!sram_ready) begin
      for (int i = 0; i < 256; i++) sram[i] <= init_val(i);
      sram_ready <= 1'b1;
    end else if (mem_we === 1'b0) begin
      sram[mem_addr[7:0]] <= mem_dout;
    end
  end

  assign mem_din = (mem_oe === 1'b0) ? sram[mem_addr[7:0]] : 16'hDEAD;

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    bit          port;   // 0 = A, 1 = B
    bit          we;
    logic [19:0] addr;
    logic [15:0] wdata;
  } txn_t;

  txn_t        cur;
  int          left = 0;        // cycles of the current access still ahead
  bit          model_valid = 1'b0;
  bit          model_ready = 1'b0;
  logic [15:0] model_mem [0:255];
  logic        exp_a_done, exp_b_done, exp_owner;
  logic [15:0] exp_a_rd, exp_b_rd;
  bit          a_elig, b_elig, pick_b;

  initial begin
    forever begin
      @(posedge clk);
      if (!model_ready) begin
        for (int i = 0; i < 256; i++) model_mem[i] = init_val(i);
        model_ready = 1'b1;
      end
      if (rst) begin
        left        = 0;
        exp_a_done  = 1'b0;
        exp_b_done  = 1'b0;
        exp_owner   = 1'b1;
        exp_a_rd    = 16'h0000;
        exp_b_rd    = 16'h0000;
        model_valid = 1'b1;
      end else if (model_valid) begin
        a_elig     = a_req && !exp_a_done;
        b_elig     = b_req && !exp_b_done;
        exp_a_done = 1'b0;
        exp_b_done = 1'b0;
        if (left > 0) begin
          left--;
          if (left == 0) begin
            if (cur.port) exp_b_done = 1'b1;
            else          exp_a_done = 1'b1;
            if (cur.we)        model_mem[cur.addr[7:0]] = cur.wdata;
            else if (cur.port) exp_b_rd = model_mem[cur.addr[7:0]];
            else               exp_a_rd = model_mem[cur.addr[7:0]];
          end
        end else if (a_elig || b_elig) begin
          pick_b    = (a_elig && b_elig) ? !exp_owner : b_elig;
          cur.port  = pick_b;
          cur.we    = pick_b ? b_we    : a_we;
          cur.addr  = pick_b ? b_addr  : a_addr;
          cur.wdata = pick_b ? b_wdata : a_wdata;
          exp_owner = pick_b;
          left      = 2;
        end
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (model_valid) begin
        check("busy",    busy,    left > 0);
        check("owner",   owner,   exp_owner);
        check("a_done",  a_done,  exp_a_done);
        check("b_done",  b_done,  exp_b_done);
        check("a_rdata", a_rdata, exp_a_rd);
        check("b_rdata", b_rdata, exp_b_rd);
        check("mem_oe",  mem_oe,  (left > 0) ? cur.we  : 1'b1);
        check("mem_we",  mem_we,  (left > 0) ? !cur.we : 1'b1);
        check("mem_drv", mem_drv_en, (left > 0) ? cur.we : 1'b0);
        check("mem_sel", {mem_ce, mem_ub, mem_lb}, 3'b000);
        if (left > 0) check("mem_addr", mem_addr, cur.addr);
        if (left > 0 && cur.we) check("mem_dout", mem_dout, cur.wdata);
        check("oe_we_excl", (mem_oe === 1'b0) && (mem_we === 1'b0), 1'b0);
        check("drv_only_wr", (mem_drv_en === 1'b1) && (mem_we !== 1'b0), 1'b0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (3) tick();

    @(negedge clk);
    check("rst_busy",  busy,     1'b0);
    check("rst_owner", owner,    1'b1);
    check("rst_oe_we", {mem_oe, mem_we, mem_drv_en}, 3'b110);
    check("rst_addr",  mem_addr, 20'h00000);
    check("rst_dout",  mem_dout, 16'h0000);
    check("rst_rdata", {a_rdata, b_rdata}, 32'h0000_0000);

    // Port A write 0x00012 <- 0xBEEF
    tick();
    rst = 1'b0;
    a_req = 1'b1; a_we = 1'b1; a_addr = 20'h00012; a_wdata = 16'hBEEF;
    @(negedge clk); check("w_idle_busy", busy, 1'b0);
    tick();
    @(negedge clk);
    check("w_acc1_strobes", {mem_oe, mem_we, mem_drv_en}, 3'b101);
    check("w_acc1_addr", mem_addr, 20'h00012);
    check("w_acc1_dout", mem_dout, 16'hBEEF);
    check("w_acc1_owner", owner, 1'b0);
    tick();
    @(negedge clk);
    check("w_acc2_we", mem_we, 1'b0);
    check("w_acc2_addr", mem_addr, 20'h00012);
    tick();
    @(negedge clk);
    check("w_done", {a_done, b_done}, 2'b10);
    check("w_done_we", mem_we, 1'b1);
    tick();
    a_req = 1'b0;
    @(negedge clk); check("w_done_once", a_done, 1'b0);

    // Port A read 0x00012 -> 0xBEEF
    a_req = 1'b1; a_we = 1'b0;
    tick();
    @(negedge clk);
    check("r_acc1_strobes", {mem_oe, mem_we, mem_drv_en}, 3'b010);
    check("r_acc1_addr", mem_addr, 20'h00012);
    tick();
    @(negedge clk); check("r_acc2_oe", mem_oe, 1'b0);
    tick();
    @(negedge clk);
    check("r_done", a_done, 1'b1);
    check("r_rdata", a_rdata, 16'hBEEF);
    check("r_b_rdata", b_rdata, 16'h0000);
    tick();
    a_req = 1'b0;

    // Inputs change and Req drops during ACC1: access of 0x00001 completes.
    a_req = 1'b1; a_we = 1'b0; a_addr = 20'h00001;
    tick();
    a_addr = 20'h00002; a_we = 1'b1; a_wdata = 16'h5555; a_req = 1'b0;
    @(negedge clk); check("hold_acc1_addr", mem_addr, 20'h00001);
    tick();
    @(negedge clk);
    check("hold_acc2_addr", mem_addr, 20'h00001);
    check("hold_acc2_oe", {mem_oe, mem_we}, 2'b01);
    tick();
    @(negedge clk);
    check("hold_done", a_done, 1'b1);
    check("hold_rdata", a_rdata, 16'h1111);
    tick();

    // Port B write 0x30 <- 0x1234, then read it back
    b_req = 1'b1; b_we = 1'b1; b_addr = 20'h00030; b_wdata = 16'h1234;
    repeat (3) tick();
    @(negedge clk);
    check("bw_done", {a_done, b_done}, 2'b01);
    check("bw_owner", owner, 1'b1);
    tick();
    b_we = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("br_rdata", b_rdata, 16'h1234);
    check("br_a_rdata", a_rdata, 16'h1111);
    tick();
    b_req = 1'b0;

    // Both ports requesting continuously: grants alternate A,B,A,B
    a_req = 1'b1; a_we = 1'b0; a_addr = 20'h00002;
    b_req = 1'b1; b_we = 1'b0; b_addr = 20'h00012;
    for (int k = 0; k < 4; k++) begin
      repeat (3) tick();
      @(negedge clk);
      check("rr_done", {a_done, b_done}, (k % 2 == 0) ? 2'b10 : 2'b01);
    end
    check("rr_a_rdata", a_rdata, 16'h2222);
    check("rr_b_rdata", b_rdata, 16'hBEEF);
    tick();
    a_req = 1'b0; b_req = 1'b0;
    repeat (4) tick();

    // Reset during ACC2 of a B read aborts it
    b_req = 1'b1; b_we = 1'b0; b_addr = 20'h00030;
    tick();
    tick();
    @(negedge clk); check("ab_acc2_oe", mem_oe, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0; b_req = 1'b0;
    @(negedge clk);
    check("ab_idle", {busy, mem_oe, b_done}, 3'b010);
    check("ab_b_rdata", b_rdata, 16'h0000);
    tick();
    @(negedge clk); check("ab_no_done", b_done, 1'b0);

    // After reset a tie goes to port A
    a_req = 1'b1; a_we = 1'b1; a_addr = 20'h00040; a_wdata = 16'hA5A5;
    b_req = 1'b1; b_we = 1'b1; b_addr = 20'h00041; b_wdata = 16'h5A5A;
    tick();
    @(negedge clk); check("tie_owner", owner, 1'b0);
    repeat (5) tick();
    a_req = 1'b0; b_req = 1'b0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
